// File: rtl/led_fade_pkg.sv
// ---------------------------------------------------------------------------
// led_fade_pkg
//
// Purpose:
//   Shared constants and helpers for the LED fade driver. Holds the default
//   brightness width, the matching full-brightness level, the perceptual
//   gamma table and the duty mapping function used by every LED cell.
//
// Configuration:
//   LED_FADE_GAMMA_EN - when defined, duty_map() looks the level up in
//                       GAMMA_LUT for a perceptually even fade. When
//                       undefined, duty_map() is the identity (linear ramp).
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package led_fade_pkg;

   // Default brightness width and the level that means "solid on".
   localparam int BR_W_DEFAULT    = 4;
   localparam int LVL_MAX_DEFAULT = (1 << BR_W_DEFAULT) - 1;

   // Perceptual correction table for a 4-bit level. Endpoints stay at 0 and
   // 15 so that solid off / solid on look the same in both builds.
   localparam logic [3:0] GAMMA_LUT [16] = '{
      4'd0,  4'd0,  4'd1,  4'd1,  4'd2,  4'd2,  4'd3,  4'd4,
      4'd5,  4'd6,  4'd7,  4'd8,  4'd10, 4'd11, 4'd13, 4'd15
   };

   // Maps a brightness level to the PWM compare threshold. The argument and
   // result are plain 32-bit values so callers of any brightness width can
   // share one function; the gamma path only ever sees 4-bit levels.
   function automatic logic [31:0] duty_map(input logic [31:0] lvl);
`ifdef LED_FADE_GAMMA_EN
      return {28'd0, GAMMA_LUT[lvl[3:0]]};
`else
      return lvl;
`endif
   endfunction

endpackage

// File: rtl/led_fade_cell.sv
// ---------------------------------------------------------------------------
// led_fade_cell
//
// Purpose:
//   One LED of the fade driver. Keeps the LED's brightness level, reloads it
//   to full whenever the pattern bit is lit, walks it down one step per
//   decay tick once released, and turns the level into a PWM drive by
//   comparing the mapped duty against the shared PWM counter.
//
// Configuration:
//   LED_FADE_GAMMA_EN - selects the gamma duty mapping (requires BR_W = 4).
//
// Ports:
//   clkin    in   board clock, all logic on posedge
//   rst      in   synchronous active-high reset
//   enable   in   1 = fade mode, 0 = bypass (output follows led_in)
//   led_in   in   this LED's pattern bit from the generator
//   tick     in   one-clock decay strobe from the top
//   pwm_cnt  in   shared PWM counter, BR_W bits
//   led_out  out  registered PWM drive for this LED
// ---------------------------------------------------------------------------
module led_fade_cell
   import led_fade_pkg::*;
#(
   parameter int BR_W = BR_W_DEFAULT
)
(
   input  logic            clkin,
   input  logic            rst,
   input  logic            enable,
   input  logic            led_in,
   input  logic            tick,
   input  logic [BR_W-1:0] pwm_cnt,
   output logic            led_out
);

   localparam logic [BR_W-1:0] LVL_MAX = '1;

`ifdef LED_FADE_GAMMA_EN
   // The gamma table only exists for 4-bit levels.
   if (BR_W != 4) begin : g_gamma_width_check
      $error("led_fade_cell: LED_FADE_GAMMA_EN requires BR_W == 4");
   end
`endif

   logic [BR_W-1:0] level_q;
   logic [BR_W-1:0] level_d;
   logic            out_q;
   logic            out_d;
   logic [31:0]     duty_w;

   // Next brightness level. Bypass mirrors the pattern into the level so
   // that switching back to fade mode starts without a stale trail. In fade
   // mode a lit bit always wins, even over a coincident tick, and decay
   // stops at zero instead of wrapping back to full brightness.
   always_comb begin
      level_d = level_q;
      if (!enable) begin
         level_d = led_in ? LVL_MAX : '0;
      end else if (led_in) begin
         level_d = LVL_MAX;
      end else if (tick && (level_q != '0)) begin
         level_d = level_q - 1'b1;
      end
   end

   // Output drive. Full level is forced solid on so the top step is a true
   // 100% duty; level zero maps to zero, which never exceeds the counter,
   // so it is solid off. Bypass passes the pattern straight to the flop.
   always_comb begin
      duty_w = duty_map(32'(level_q));
      out_d  = led_in;
      if (enable) begin
         out_d = (level_q == LVL_MAX) || (duty_w > 32'(pwm_cnt));
      end
   end

   // Level and output registers; reset kills any fade in progress at once.
   always_ff @(posedge clkin) begin
      if (rst) begin
         level_q <= '0;
         out_q   <= 1'b0;
      end else begin
         level_q <= level_d;
         out_q   <= out_d;
      end
   end

   assign led_out = out_q;

endmodule

// File: rtl/led_fade_driver.sv
// ---------------------------------------------------------------------------
// led_fade_driver
//
// Purpose:
//   Downstream stage of the LED pattern generator. Every lit LED snaps to
//   full brightness and, once released, fades out over programmable decay
//   steps using per-LED PWM, producing a glow trail behind the scanner.
//   This top level only owns the shared timing: the PWM prescaler and
//   counter, and the decay counter that emits the one-clock decay tick.
//   Each LED is handled by its own led_fade_cell.
//
// Configuration:
//   LED_FADE_GAMMA_EN - gamma-corrected duty mapping in every cell
//                       (requires BR_W = 4); linear ramp when undefined.
//
// Parameters:
//   NLED      number of LEDs / pattern width
//   BR_W      brightness level width
//   PWM_DIV   clocks per PWM counter step (>= 1)
//   DECAY_DIV base clocks per decay step; step = DECAY_DIV * (decay + 1)
//
// Ports:
//   clkin   in   board clock, all logic on posedge
//   rst     in   synchronous active-high reset
//   LEDin   in   NLED-bit pattern from the generator, sampled every clock
//   decay   in   4-bit fade-rate switches
//   enable  in   1 = fade mode, 0 = bypass
//   LEDout  out  NLED-bit registered PWM LED drive
// ---------------------------------------------------------------------------
module led_fade_driver
   import led_fade_pkg::*;
#(
   parameter int NLED      = 10,
   parameter int BR_W      = BR_W_DEFAULT,
   parameter int PWM_DIV   = 64,
   parameter int DECAY_DIV = 100000
)
(
   input  logic            clkin,
   input  logic            rst,
   input  logic [NLED-1:0] LEDin,
   input  logic [3:0]      decay,
   input  logic            enable,
   output logic [NLED-1:0] LEDout
);

   if (PWM_DIV < 1) begin : g_pwm_div_check
      $error("led_fade_driver: PWM_DIV must be at least 1");
   end

   localparam logic [31:0] PDIV_LAST = 32'(PWM_DIV - 1);
   localparam logic [31:0] DECAY_LEN = 32'(DECAY_DIV);

   logic [31:0]     pdiv_q;
   logic [31:0]     pdiv_d;
   logic [BR_W-1:0] pwm_cnt_q;
   logic [BR_W-1:0] pwm_cnt_d;
   logic [31:0]     decay_cnt_q;
   logic [31:0]     decay_cnt_d;
   logic            tick_q;
   logic            tick_d;
   logic [31:0]     decay_limit_w;

   // PWM timing. The prescaler counts clocks within one PWM step; the PWM
   // counter wraps naturally from all-ones back to zero, so one PWM period
   // is PWM_DIV * 2^BR_W clocks.
   always_comb begin
      pdiv_d    = pdiv_q + 32'd1;
      pwm_cnt_d = pwm_cnt_q;
      if (pdiv_q >= PDIV_LAST) begin
         pdiv_d    = 32'd0;
         pwm_cnt_d = pwm_cnt_q + 1'b1;
      end
   end

   // Decay timing. The limit is recomputed from the live switch value every
   // clock, and the greater-or-equal compare means that lowering the rate
   // below the current count fires the tick on the next clock instead of
   // letting the counter run all the way around.
   always_comb begin
      decay_limit_w = (DECAY_LEN * ({28'd0, decay} + 32'd1)) - 32'd1;
      decay_cnt_d   = decay_cnt_q + 32'd1;
      tick_d        = 1'b0;
      if (decay_cnt_q >= decay_limit_w) begin
         decay_cnt_d = 32'd0;
         tick_d      = 1'b1;
      end
   end

   // Shared counter registers; the counters keep running in bypass mode.
   always_ff @(posedge clkin) begin
      if (rst) begin
         pdiv_q      <= 32'd0;
         pwm_cnt_q   <= '0;
         decay_cnt_q <= 32'd0;
         tick_q      <= 1'b0;
      end else begin
         pdiv_q      <= pdiv_d;
         pwm_cnt_q   <= pwm_cnt_d;
         decay_cnt_q <= decay_cnt_d;
         tick_q      <= tick_d;
      end
   end

   // One fade cell per LED, all sharing the PWM counter and decay tick.
   for (genvar i = 0; i < NLED; i++) begin : g_cell
      led_fade_cell #(
         .BR_W    (BR_W)
      ) u_cell (
         .clkin   (clkin),
         .rst     (rst),
         .enable  (enable),
         .led_in  (LEDin[i]),
         .tick    (tick_q),
         .pwm_cnt (pwm_cnt_q),
         .led_out (LEDout[i])
      );
   end

endmodule

// File: tb/tb_led_fade_driver.sv
// ---------------------------------------------------------------------------
// tb_led_fade_driver
//
// Purpose:
//   Self-checking bench for led_fade_driver with PWM_DIV = 1 and
//   DECAY_DIV = 4. A vector table covers reset and bypass/fade switching;
//   hand-written sequences cover the fade trail, load-versus-tick priority,
//   reset mid-fade, decay rate changes and PWM duty per level.
//
// Configuration:
//   LED_FADE_GAMMA_EN - expected duties follow the gamma table when defined.
// ---------------------------------------------------------------------------
module tb_led_fade_driver;

   localparam int NLED      = 10;
   localparam int BR_W      = 4;
   localparam int PWM_DIV   = 1;
   localparam int DECAY_DIV = 4;

   logic            clkin = 1'b0;
   logic            rst;
   logic [NLED-1:0] led_in;
   logic [3:0]      decay;
   logic            enable;
   logic [NLED-1:0] led_out;

   int pass_count  = 0;
   int check_count = 0;
   int cyc         = 0;

   int gamma_tbl [16] = '{0, 0, 1, 1, 2, 2, 3, 4, 5, 6, 7, 8, 10, 11, 13, 15};

   typedef struct {
      logic            r;
      logic            e;
      logic [NLED-1:0] l;
      logic [NLED-1:0] exp_out;
   } vec_t;

   vec_t vecs [14];

   led_fade_driver #(
      .NLED      (NLED),
      .BR_W      (BR_W),
      .PWM_DIV   (PWM_DIV),
      .DECAY_DIV (DECAY_DIV)
   ) dut (
      .clkin  (clkin),
      .rst    (rst),
      .LEDin  (led_in),
      .decay  (decay),
      .enable (enable),
      .LEDout (led_out)
   );

   // Free-running board clock, posedge at 5, 15, 25, ...
   always #5 clkin = ~clkin;

   // Expected duty threshold for a level in the current build.
   function automatic int map_lvl(input int lv);
`ifdef LED_FADE_GAMMA_EN
      return gamma_tbl[lv];
`else
      return lv;
`endif
   endfunction

   // Level held after posedge k when the LED was loaded at posedge 1 and the
   // decay step is 'per' clocks (first decrement lands on posedge per+1).
   function automatic int lvl_at(input int k, input int per);
      int v;
      if (k < 1) return 0;
      v = 15 - (k - 1) / per;
      return (v < 0) ? 0 : v;
   endfunction

   function automatic logic exp_bit(input int lv, input int p);
      return (lv == 15) || (map_lvl(lv) > p);
   endfunction

   // Drive one clock of inputs, then sample just after the edge.
   task automatic applyStimulus(input logic r, input logic e,
                                input logic [NLED-1:0] l, input logic [3:0] d);
      rst    = r;
      enable = e;
      led_in = l;
      decay  = d;
      @(posedge clkin);
      #1;
      cyc++;
   endtask

   task automatic checkOutput(input string name, input int act, input int exp_v);
      check_count++;
      if (act == exp_v) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp_v);
      end
   endtask

   // Reset, then load 'mask' at posedge 1 through either fade or bypass mode.
   task automatic startLoad(input logic e, input logic [NLED-1:0] mask, input logic [3:0] d);
      applyStimulus(1'b1, 1'b1, '0, d);
      cyc = 0;
      applyStimulus(1'b0, e, mask, d);
   endtask

   // Run the fade with LEDin low and check every output sample.
   task automatic runFade(input string name, input logic [NLED-1:0] mask,
                          input int per, input logic [3:0] d, input int last_k);
      logic [NLED-1:0] exp_v;
      while (cyc < last_k) begin
         applyStimulus(1'b0, 1'b1, '0, d);
         exp_v = exp_bit(lvl_at(cyc - 1, per), (cyc - 1) % 16) ? mask : '0;
         checkOutput(name, int'(led_out), int'(exp_v));
      end
   endtask

   initial begin
      int hi14;
      int hi13;
      int hi12;

      rst    = 1'b1;
      enable = 1'b1;
      led_in = '0;
      decay  = 4'd0;

      // Table: reset, bypass patterns, fade-mode load latency, re-enable.
      vecs[0]  = '{1'b1, 1'b0, 10'h3FF, 10'h000};
      vecs[1]  = '{1'b0, 1'b0, 10'h2AA, 10'h2AA};
      vecs[2]  = '{1'b0, 1'b0, 10'h155, 10'h155};
      vecs[3]  = '{1'b0, 1'b0, 10'h000, 10'h000};
      vecs[4]  = '{1'b0, 1'b0, 10'h3FF, 10'h3FF};
      vecs[5]  = '{1'b0, 1'b0, 10'h001, 10'h001};
      vecs[6]  = '{1'b0, 1'b0, 10'h200, 10'h200};
      vecs[7]  = '{1'b1, 1'b0, 10'h3FF, 10'h000};
      vecs[8]  = '{1'b0, 1'b1, 10'h3FF, 10'h000};
      vecs[9]  = '{1'b0, 1'b1, 10'h3FF, 10'h3FF};
      vecs[10] = '{1'b0, 1'b1, 10'h3FF, 10'h3FF};
      vecs[11] = '{1'b0, 1'b0, 10'h000, 10'h000};
      vecs[12] = '{1'b0, 1'b0, 10'h3FF, 10'h3FF};
      vecs[13] = '{1'b0, 1'b1, 10'h000, 10'h3FF};

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].r, vecs[i].e, vecs[i].l, 4'd0);
         checkOutput($sformatf("table[%0d]", i), int'(led_out), int'(vecs[i].exp_out));
      end

      // Reset with all pattern bits lit: dark during reset, solid 2 clocks on.
      applyStimulus(1'b1, 1'b1, 10'h3FF, 4'd0);
      checkOutput("reset_out", int'(led_out), 0);
      applyStimulus(1'b0, 1'b1, 10'h3FF, 4'd0);
      checkOutput("reset_plus1", int'(led_out), 0);
      applyStimulus(1'b0, 1'b1, 10'h3FF, 4'd0);
      checkOutput("reset_plus2", int'(led_out), 'h3FF);

      // Single LED full fade to dark, checked every clock, no wrap at the end.
      startLoad(1'b1, 10'h001, 4'd0);
      checkOutput("fade_load", int'(led_out), 0);
      runFade("fade_single", 10'h001, 4, 4'd0, 72);

      // Bypass load of 0x2AA, then fade mode: odd bits trail, even bits dark.
      startLoad(1'b0, 10'h2AA, 4'd0);
      checkOutput("bypass_out", int'(led_out), 'h2AA);
      runFade("bypass_trail", 10'h2AA, 4, 4'd0, 70);

      // Load LED3 on the exact tick clock while its level is 5.
      startLoad(1'b1, 10'h008, 4'd0);
      while (cyc < 44) applyStimulus(1'b0, 1'b1, '0, 4'd0);
      checkOutput("tick_at_44", int'(dut.tick_q), 1);
      checkOutput("level5_dim", int'(led_out), 0);
      applyStimulus(1'b0, 1'b1, 10'h008, 4'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, '0, 4'd0);
         checkOutput("load_beats_tick", int'(led_out), 'h008);
      end

      // Reset in the middle of that fade leaves no glow behind.
      applyStimulus(1'b1, 1'b1, '0, 4'd0);
      checkOutput("reset_midfade", int'(led_out), 0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, '0, 4'd0);
         checkOutput("no_residual", int'(led_out), 0);
      end

      // Lowering decay below the running count fires the tick next clock.
      applyStimulus(1'b1, 1'b1, '0, 4'd3);
      cyc = 0;
      while (cyc < 10) applyStimulus(1'b0, 1'b1, '0, 4'd3);
      checkOutput("dcnt_at_10", int'(dut.decay_cnt_q), 10);
      checkOutput("no_tick_yet", int'(dut.tick_q), 0);
      applyStimulus(1'b0, 1'b1, '0, 4'd0);
      checkOutput("tick_after_change", int'(dut.tick_q), 1);
      checkOutput("dcnt_cleared", int'(dut.decay_cnt_q), 0);
      applyStimulus(1'b0, 1'b1, '0, 4'd0);
      checkOutput("tick_one_clock", int'(dut.tick_q), 0);
      checkOutput("dcnt_restart", int'(dut.decay_cnt_q), 1);

      // Duty per 16-clock window with a 16-clock decay step (decay = 3).
      startLoad(1'b1, 10'h001, 4'd3);
      hi14 = 0;
      hi13 = 0;
      hi12 = 0;
      while (cyc < 65) begin
         applyStimulus(1'b0, 1'b1, '0, 4'd3);
         if (cyc >= 18 && cyc <= 33) hi14 += int'(led_out[0]);
         if (cyc >= 34 && cyc <= 49) hi13 += int'(led_out[0]);
         if (cyc >= 50 && cyc <= 65) hi12 += int'(led_out[0]);
      end
      checkOutput("duty_lvl14", hi14, map_lvl(14));
      checkOutput("duty_lvl13", hi13, map_lvl(13));
      checkOutput("duty_lvl12", hi12, map_lvl(12));

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
